// File: rtl/corr_engine_param.sv
// Time-multiplexed correlator: NBLK blocks x TAPS taps against one of NBANK coefficient banks.
// Result TAPS+2 edges after accept; in_ready low from accept until out_valid & out_ready.
module corr_engine_param #(
    parameter int DW    = 9,
    parameter int NBLK  = 3,
    parameter int TAPS  = 64,
    parameter int NBANK = 4,
    parameter int ACCW  = 2*DW + $clog2(NBLK*TAPS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic signed [DW-1:0]              in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic signed [DW-1:0]              shift_out,
    output logic                              shift_valid,
    input  logic [$clog2(NBANK)-1:0]          bank_sel,
    input  logic [$clog2(NBANK)-1:0]          coeff_bank,
    input  logic [$clog2(NBLK*TAPS)-1:0]      coeff_index,
    input  logic signed [DW-1:0]              coeff_value,
    input  logic                              coeff_write,
    output logic                              coeff_err,
    input  logic [ACCW-1:0]                   threshold,
    output logic signed [ACCW-1:0]            out_data,
    output logic                              out_peak,
    output logic                              out_valid,
    input  logic                              out_ready
);
    localparam int NLINE = NBLK * TAPS;
    localparam int TW    = $clog2(TAPS);
    localparam int BW    = $clog2(NBANK);
    localparam int IW    = $clog2(NLINE);
    localparam int XW    = ACCW - 2*DW;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SUM, S_OUT} state_t;

    state_t                   state_q;
    logic [TW-1:0]            cnt_q;
    logic [BW-1:0]            bank_q;
    logic signed [DW-1:0]     line_q [NBLK][TAPS];
    logic signed [DW-1:0]     coef_q [NBLK][NBANK*TAPS];
    logic signed [ACCW-1:0]   acc_q  [NBLK];
    logic signed [ACCW-1:0]   out_data_q;
    logic                     out_valid_q;
    logic                     out_peak_q;
    logic signed [DW-1:0]     shift_out_q;
    logic                     shift_valid_q;
    logic                     coeff_err_q;

    logic signed [2*DW-1:0]   prod_d [NBLK];
    logic signed [ACCW-1:0]   sum_d;
    logic [ACCW:0]            ext_d;
    logic [ACCW:0]            mag_d;
    logic                     peak_d;

    logic [IW-1:0]            wr_blk;
    logic [TW-1:0]            wr_tap;
    logic                     wr_in_range;
    logic                     wr_ok;

    assign in_ready    = (state_q == S_IDLE);
    assign shift_out   = shift_out_q;
    assign shift_valid = shift_valid_q;
    assign coeff_err   = coeff_err_q;
    assign out_data    = out_data_q;
    assign out_peak    = out_peak_q;
    assign out_valid   = out_valid_q;

    // The bank feeding an in-flight pass is frozen; every other bank stays writable.
    assign wr_blk      = coeff_index >> TW;
    assign wr_tap      = coeff_index[TW-1:0];
    assign wr_in_range = {1'b0, coeff_index} < (IW+1)'(NLINE);
    assign wr_ok       = coeff_write & ~reset & wr_in_range
                         & ~((state_q != S_IDLE) && (coeff_bank == bank_q));

    always_comb begin
        sum_d = '0;
        for (int b = 0; b < NBLK; b++) begin
            prod_d[b] = line_q[b][cnt_q] * coef_q[b][{bank_q, cnt_q}];
            sum_d     = sum_d + acc_q[b];
        end
        // One extra bit so the most negative result still has a representable magnitude.
        ext_d  = {sum_d[ACCW-1], sum_d};
        mag_d  = ext_d[ACCW] ? (~ext_d + (ACCW+1)'(1)) : ext_d;
        peak_d = (mag_d >= {1'b0, threshold});
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NBLK; b++) begin
            if (wr_ok && (wr_blk == IW'(b))) begin
                coef_q[b][{coeff_bank, wr_tap}] <= coeff_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bank_q        <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_peak_q    <= 1'b0;
            shift_out_q   <= '0;
            shift_valid_q <= 1'b0;
            coeff_err_q   <= 1'b0;
            for (int b = 0; b < NBLK; b++) begin
                acc_q[b] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    line_q[b][t] <= '0;
                end
            end
        end else begin
            shift_valid_q <= 1'b0;
            coeff_err_q   <= coeff_write & ~wr_ok;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        line_q[0][0] <= in_data;
                        for (int b = 1; b < NBLK; b++) begin
                            line_q[b][0] <= line_q[b-1][TAPS-1];
                        end
                        for (int b = 0; b < NBLK; b++) begin
                            for (int t = 1; t < TAPS; t++) begin
                                line_q[b][t] <= line_q[b][t-1];
                            end
                            acc_q[b] <= '0;
                        end
                        shift_out_q   <= line_q[NBLK-1][TAPS-1];
                        shift_valid_q <= 1'b1;
                        bank_q        <= bank_sel;
                        cnt_q         <= '0;
                        state_q       <= S_MAC;
                    end
                end
                S_MAC: begin
                    for (int b = 0; b < NBLK; b++) begin
                        acc_q[b] <= acc_q[b] + {{XW{prod_d[b][2*DW-1]}}, prod_d[b]};
                    end
                    cnt_q <= cnt_q + TW'(1);
                    if (cnt_q == TW'(TAPS-1)) begin
                        state_q <= S_SUM;
                    end
                end
                S_SUM: begin
                    out_data_q <= sum_d;
                    out_peak_q <= peak_d;
                    state_q    <= S_OUT;
                end
                S_OUT: begin
                    // First OUT cycle raises the registered valid; later cycles wait for the sink.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_corr_engine_param.sv
// Bench for corr_engine_param: a transaction-level model predicts every output each cycle.
module tb_corr_engine_param;
    localparam int DW = 9, NBLK = 3, TAPS = 64, NBANK = 4;
    localparam int NL = NBLK * TAPS;
    localparam int ACCW = 2*DW + $clog2(NL);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [DW-1:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [DW-1:0] shift_out;
    logic shift_valid;
    logic [1:0] bank_sel = '0;
    logic [1:0] coeff_bank = '0;
    logic [7:0] coeff_index = '0;
    logic signed [DW-1:0] coeff_value = '0;
    logic coeff_write = 1'b0;
    logic coeff_err;
    logic [ACCW-1:0] threshold = '0;
    logic signed [ACCW-1:0] out_data;
    logic out_peak;
    logic out_valid;
    logic out_ready = 1'b0;

    corr_engine_param dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .shift_out(shift_out), .shift_valid(shift_valid),
        .bank_sel(bank_sel), .coeff_bank(coeff_bank), .coeff_index(coeff_index),
        .coeff_value(coeff_value), .coeff_write(coeff_write), .coeff_err(coeff_err),
        .threshold(threshold), .out_data(out_data), .out_peak(out_peak),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int  m_line [NL];
    int  m_coef [NBANK][NL];
    bit  m_busy, m_vld, m_peak, m_svld, m_err;
    int  m_data, m_pend, m_sout, m_cnt, m_bank;
    longint m_mag;
    int  n_checks = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;
    bit  rand_rdy = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a pass is a dot product of the line snapshot with the latched bank.
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_vld = 0; m_peak = 0; m_svld = 0; m_err = 0;
            m_data = 0; m_bank = 0;
            foreach (m_line[i]) m_line[i] = 0;
        end else begin
            m_svld = 0;
            m_err = 0;
            if (coeff_write) begin
                if (coeff_index < NL && !(m_busy && int'(coeff_bank) == m_bank))
                    m_coef[coeff_bank][coeff_index] = int'(coeff_value);
                else
                    m_err = 1;
            end
            if (m_vld && out_ready) begin
                m_vld = 0;
                m_busy = 0;
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt == TAPS + 1) begin
                    m_data = m_pend;
                    m_mag = (m_pend < 0) ? -longint'(m_pend) : longint'(m_pend);
                    m_peak = (m_mag >= longint'(threshold));
                end
                if (m_cnt == TAPS + 2) m_vld = 1;
            end else if (in_valid) begin
                m_sout = m_line[NL-1];
                for (int i = NL-1; i > 0; i--) m_line[i] = m_line[i-1];
                m_line[0] = int'(in_data);
                m_svld = 1;
                m_bank = int'(bank_sel);
                m_busy = 1;
                m_cnt = 0;
                m_pend = 0;
                for (int i = 0; i < NL; i++) m_pend += m_line[i] * m_coef[m_bank][i];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, !m_busy);
            check("out_valid", out_valid, m_vld);
            check("out_data", out_data, m_data);
            check("out_peak", out_peak, m_peak);
            check("shift_valid", shift_valid, m_svld);
            if (m_svld) check("shift_out", shift_out, m_sout);
            check("coeff_err", coeff_err, m_err);
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int b, input int idx, input int v);
        coeff_write = 1'b1;
        coeff_bank = 2'(b);
        coeff_index = 8'(idx);
        coeff_value = 9'(v);
        tick();
        coeff_write = 1'b0;
    endtask

    task automatic send(input int v, input int b);
        int n;
        n = 0;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check("send_timeout", in_ready, 1);
        in_data = 9'(v);
        bank_sel = 2'(b);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 400) begin
            tick();
            n++;
        end
        check("wait_out_valid", out_valid, 1);
    endtask

    task automatic rand_cycle();
        coeff_write = ($urandom_range(0, 3) == 0);
        coeff_bank = 2'($urandom_range(0, 3));
        coeff_index = 8'($urandom_range(0, 255));
        coeff_value = 9'($urandom_range(0, 511));
        tick();
        coeff_write = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;

        for (int j = 0; j < NL; j++) begin
            wr(0, j, (j == 0) ? 1 : 0);
            wr(1, j, j + 1);
            wr(2, j, -256);
            wr(3, j, int'($urandom_range(0, 511)) - 256);
        end

        // Single-tap bank: exact latency, peak at equality, then a stalled sink.
        threshold = 26'd5;
        out_ready = 1'b0;
        send(5, 0);
        repeat (TAPS + 1) tick();
        check("t1_not_yet_valid", out_valid, 0);
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 5);
        check("t1_peak", out_peak, 1);
        in_data = 9'sd7;
        bank_sel = 2'd0;
        in_valid = 1'b1;
        repeat (10) begin
            tick();
            check("t4_hold_data", out_data, 5);
            check("t4_hold_valid", out_valid, 1);
            check("t4_stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        threshold = 26'd8;
        wait_out();
        check("t4_next_data", out_data, 7);
        check("t4_next_peak", out_peak, 0);
        tick();

        // Impulse walks through bank 1 ramp.
        reset = 1'b1;
        tick();
        check("rst2_out_valid", out_valid, 0);
        check("rst2_in_ready", in_ready, 1);
        reset = 1'b0;
        threshold = '1;
        for (int j = 0; j < NL; j++) begin
            send((j == 0) ? 1 : 0, 1);
            wait_out();
            check("t2_ramp", out_data, j + 1);
        end
        tick();

        // Worst-case magnitude: no wrap, peak at the exact threshold.
        threshold = 26'd12582912;
        for (int j = 0; j < NL - 1; j++) begin
            send(-256, 2);
            wait_out();
        end
        send(-256, 2);
        wait_out();
        check("t3_full_scale", out_data, 12582912);
        check("t3_peak", out_peak, 1);
        tick();

        // Frozen bank rejects writes mid-pass; other banks and same-edge writes land.
        threshold = 26'd1000;
        send(3, 3);
        repeat (5) tick();
        wr(3, 7, 99);
        check("t5_err_locked", coeff_err, 1);
        wr(0, 1, 3);
        check("t5_err_other", coeff_err, 0);
        wr(3, 200, 5);
        check("t5_err_range", coeff_err, 1);
        wait_out();
        tick();
        while (!in_ready) tick();
        coeff_write = 1'b1;
        coeff_bank = 2'd3;
        coeff_index = 8'd0;
        coeff_value = 9'sd50;
        in_data = 9'sd2;
        bank_sel = 2'd3;
        in_valid = 1'b1;
        tick();
        coeff_write = 1'b0;
        in_valid = 1'b0;
        wait_out();
        tick();
        send(4, 0);
        wait_out();
        check("t5_bank0_write", out_data, 4 + 3 * 2);
        tick();

        // Reset mid-pass aborts the pass and empties the line.
        send(9, 0);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_in_ready", in_ready, 1);
        repeat (80) tick();
        send(4, 0);
        check("t6_shift_valid", shift_valid, 1);
        check("t6_shift_out", shift_out, 0);
        wait_out();
        tick();

        rand_rdy = 1'b1;
        repeat (40) begin
            threshold = 26'($urandom_range(0, 1 << 20));
            send(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 3)));
            repeat ($urandom_range(40, 90)) rand_cycle();
        end
        rand_rdy = 1'b0;
        #2;
        out_ready = 1'b1;
        repeat (200) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
